// File: rtl/i2s_rx_frame_scheduler.sv
// Drains completed I2S receive frames from the circular bit buffer into a 32-bit valid/ready word stream.
// Optional I2S_FRAME_SCHED_RESYNC_EN: on overrun, abort the frame and jump to the newest completed frame.
module i2s_rx_frame_scheduler #(
    parameter int CIRC_BUF_BITS = 3
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic                       enable_i,
    input  logic [CIRC_BUF_BITS-1:0]   last_good_frame_idx_i,
    output logic [CIRC_BUF_BITS+7:0]   ram_read_addr_o,
    output logic                       ram_read_en_o,
    input  logic                       ram_read_data_i,
    output logic [31:0]                m_data_o,
    output logic                       m_valid_o,
    input  logic                       m_ready_i,
    output logic                       m_last_o,
    output logic                       overrun_o,
    input  logic                       overrun_clr_i,
    output logic                       busy_o
);
    localparam int FB = CIRC_BUF_BITS;
    localparam int PW = CIRC_BUF_BITS + 1;
    localparam logic [PW-1:0] PEND_MAX = PW'((1 << FB) - 1);

    typedef enum logic [1:0] {IDLE, READ, DRAIN} state_t;

    state_t        state_q, state_d;
    logic [FB-1:0] last_idx_q, rd_frame_q, rd_frame_d;
    logic [PW-1:0] pending_q, pending_d;
    logic [7:0]    bit_q;
    logic          rd_vld_q, rd_last_q;
    logic [31:0]   asm_q;
    logic [5:0]    asm_cnt_q;
    logic          asm_last_q;
    logic [31:0]   out_data_q;
    logic          out_valid_q, out_last_q;
    logic          overrun_q, busy_q;

    logic          completion, accept, out_holds_last, ovr, abort;
    logic          word_done, word_last, xfer, issue, drain_done, inc, dec;
    logic [5:0]    new_cnt, next_cnt;
    logic [31:0]   full_word;

    // Datapath: the bit returning this cycle completes a word without an extra register stage,
    // so the first word is valid 33 cycles after the first read.
    always_comb begin
        completion     = last_good_frame_idx_i != last_idx_q;
        accept         = out_valid_q & m_ready_i;
        out_holds_last = out_valid_q & out_last_q;
        ovr            = completion & (pending_q == PEND_MAX);
`ifdef I2S_FRAME_SCHED_RESYNC_EN
        abort          = ovr;
`else
        abort          = 1'b0;
`endif
        new_cnt    = asm_cnt_q + {5'd0, rd_vld_q};
        word_done  = new_cnt == 6'd32;
        full_word  = rd_vld_q ? {asm_q[30:0], ram_read_data_i} : asm_q;
        word_last  = rd_vld_q ? rd_last_q : asm_last_q;
        xfer       = word_done & (~out_valid_q | m_ready_i) & ~abort;
        next_cnt   = xfer ? 6'd0 : new_cnt;
        issue      = (state_q == READ) & (next_cnt < 6'd32) & ~abort;
        drain_done = (asm_cnt_q == 6'd0) & ~rd_vld_q;
    end

    always_comb begin
        state_d    = state_q;
        rd_frame_d = rd_frame_q;
        pending_d  = pending_q;
        inc        = completion & ~ovr;
        dec        = accept & out_last_q & (pending_q != '0);
        case (state_q)
            IDLE: begin
                if (!enable_i)
                    rd_frame_d = last_good_frame_idx_i + FB'(1);
                // a frame whose last word still sits in the output register is already read
                else if (pending_q > {{FB{1'b0}}, out_holds_last})
                    state_d = READ;
            end
            READ: begin
                if (issue && bit_q == 8'hFF)
                    state_d = DRAIN;
            end
            DRAIN: begin
                if (drain_done) begin
                    state_d    = IDLE;
                    rd_frame_d = rd_frame_q + FB'(1);
                end
            end
            default: state_d = IDLE;
        endcase
        case ({inc, dec})
            2'b10:   pending_d = pending_q + PW'(1);
            2'b01:   pending_d = pending_q - PW'(1);
            default: pending_d = pending_q;
        endcase
        if (state_q == IDLE && !enable_i)
            pending_d = '0;
        if (abort) begin
            state_d    = IDLE;
            rd_frame_d = last_good_frame_idx_i;
            pending_d  = PW'(1) + {{FB{1'b0}}, out_holds_last & ~m_ready_i};
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= IDLE;
            last_idx_q  <= last_good_frame_idx_i;
            rd_frame_q  <= last_good_frame_idx_i + FB'(1);
            pending_q   <= '0;
            bit_q       <= '0;
            rd_vld_q    <= 1'b0;
            rd_last_q   <= 1'b0;
            asm_q       <= '0;
            asm_cnt_q   <= '0;
            asm_last_q  <= 1'b0;
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
            overrun_q   <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            last_idx_q <= last_good_frame_idx_i;
            rd_frame_q <= rd_frame_d;
            pending_q  <= pending_d;
            overrun_q  <= ovr | (overrun_q & ~overrun_clr_i);
            busy_q     <= (state_d != IDLE) | (pending_d != '0);
            if (state_q == IDLE)
                bit_q <= '0;
            else if (issue)
                bit_q <= bit_q + 8'd1;
            if (abort) begin
                rd_vld_q   <= 1'b0;
                rd_last_q  <= 1'b0;
                asm_cnt_q  <= '0;
                asm_last_q <= 1'b0;
            end else begin
                rd_vld_q  <= issue;
                rd_last_q <= issue & (bit_q == 8'hFF);
                asm_cnt_q <= next_cnt;
                if (xfer)
                    asm_last_q <= 1'b0;
                else if (word_done) begin
                    asm_q      <= full_word;
                    asm_last_q <= word_last;
                end else if (rd_vld_q)
                    asm_q <= {asm_q[30:0], ram_read_data_i};
            end
            if (xfer) begin
                out_valid_q <= 1'b1;
                out_data_q  <= full_word;
                out_last_q  <= word_last;
            end else if (accept) begin
                out_valid_q <= 1'b0;
                out_last_q  <= 1'b0;
            end
        end
    end

    assign ram_read_en_o   = issue;
    assign ram_read_addr_o = (state_q == IDLE) ? '0 : {rd_frame_q, bit_q};
    assign m_data_o        = out_data_q;
    assign m_valid_o       = out_valid_q;
    assign m_last_o        = out_last_q;
    assign overrun_o       = overrun_q;
    assign busy_o          = busy_q;
endmodule

// File: tb/tb_i2s_rx_frame_scheduler.sv
// Directed bench for i2s_rx_frame_scheduler: RAM model, stream monitor, one task per scenario.
module tb_i2s_rx_frame_scheduler;
    logic        clk = 1'b0;
    logic        rst, enable, en, valid, ready, last, ovr, clr, busy;
    logic        din = 1'b0;
    logic [2:0]  idx;
    logic [10:0] addr;
    logic [31:0] data;
    int          tests = 0;
    int          fails = 0;
    int          cyc = 0;
    logic        mem [0:2047];
    logic [10:0] rd_addr_q[$];
    int          rd_cyc_q[$];
    logic [32:0] w_q[$];
    int          w_cyc_q[$];

    i2s_rx_frame_scheduler #(.CIRC_BUF_BITS(3)) dut (
        .clk_i(clk), .rst_i(rst), .enable_i(enable), .last_good_frame_idx_i(idx),
        .ram_read_addr_o(addr), .ram_read_en_o(en), .ram_read_data_i(din),
        .m_data_o(data), .m_valid_o(valid), .m_ready_i(ready), .m_last_o(last),
        .overrun_o(ovr), .overrun_clr_i(clr), .busy_o(busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) if (en) din <= mem[addr];

    // inputs only change at posedge+1, so negedge values are what the next edge sees
    always @(negedge clk) begin
        cyc <= cyc + 1;
        if (en) begin
            rd_addr_q.push_back(addr);
            rd_cyc_q.push_back(cyc);
        end
        if (valid && ready) begin
            w_q.push_back({last, data});
            w_cyc_q.push_back(cyc);
        end
    end

    function automatic logic [31:0] pat(input int f, input int k);
        logic [31:0] t;
        if (f == 6 && k == 0) return 32'hA5A5_A5A5;
        if (f == 6 && k == 7) return 32'h0000_0001;
        t = 32'h9E37_79B9 * 32'(f * 8 + k + 1);
        return t ^ {t[15:0], t[31:16]};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic sample();
        @(negedge clk);
        #1;
    endtask

    task automatic clear_logs();
        rd_addr_q.delete();
        rd_cyc_q.delete();
        w_q.delete();
        w_cyc_q.delete();
    endtask

    task automatic test_reset();
        repeat (3) step();
        sample();
        tests++;
        if ({valid, en, last, ovr, busy, data, addr} !== 48'd0) begin
            fails++;
            $display("FAIL reset_held got v%b e%b l%b o%b b%b d%h a%h exp all 0", valid, en, last, ovr, busy, data, addr);
        end
        step();
        rst = 1'b0;
        sample();
        tests++;
        if ({valid, en, busy, addr} !== 14'd0) begin
            fails++;
            $display("FAIL reset_release got v%b e%b b%b a%h exp all 0", valid, en, busy, addr);
        end
    endtask

    task automatic test_single_frame();
        int errs;
        step();
        clear_logs();
        enable = 1'b1;
        ready = 1'b1;
        idx = 3'd6;
        for (int i = 0; i < 600 && w_q.size() < 8; i++) sample();
        tests++;
        if (w_q.size() != 8) begin fails++; $display("FAIL single_word_count got %0d exp 8", w_q.size()); end
        errs = 0;
        for (int i = 0; i < 256; i++) if (rd_addr_q[i] !== 11'(6 * 256 + i)) errs++;
        tests++;
        if (rd_addr_q.size() != 256 || errs != 0) begin
            fails++; $display("FAIL single_addr_seq got %0d reads %0d bad exp 256 reads 0 bad", rd_addr_q.size(), errs);
        end
        tests++;
        if (w_q[0] !== {1'b0, 32'hA5A5_A5A5}) begin fails++; $display("FAIL single_word0 got %h exp 0a5a5a5a5", w_q[0]); end
        tests++;
        if (w_q[7] !== {1'b1, 32'h0000_0001}) begin fails++; $display("FAIL single_word7 got %h exp 100000001", w_q[7]); end
        errs = 0;
        for (int k = 1; k < 7; k++) if (w_q[k] !== {1'b0, pat(6, k)}) errs++;
        tests++;
        if (errs != 0) begin fails++; $display("FAIL single_mid_words got %0d bad exp 0", errs); end
        tests++;
        if (w_cyc_q[0] - rd_cyc_q[0] != 33) begin
            fails++; $display("FAIL single_latency got %0d exp 33", w_cyc_q[0] - rd_cyc_q[0]);
        end
        repeat (5) sample();
        tests++;
        if (busy !== 1'b0 || en !== 1'b0) begin fails++; $display("FAIL single_idle got b%b e%b exp 0 0", busy, en); end
    endtask

    task automatic test_stall();
        int errs, snap;
        logic pv;
        logic [31:0] pd;
        step();
        clear_logs();
        idx = 3'd7;
        for (int i = 0; i < 200 && rd_addr_q.size() < 40; i++) sample();
        step();
        ready = 1'b0;
        errs = 0; snap = 0; pv = 1'b0; pd = '0;
        for (int i = 0; i < 100; i++) begin
            sample();
            if (pv && (valid !== 1'b1 || data !== pd)) errs++;
            pv = valid;
            pd = data;
            if (i == 60) snap = rd_addr_q.size();
        end
        tests++;
        if (errs != 0) begin fails++; $display("FAIL stall_stable got %0d changes exp 0", errs); end
        tests++;
        if (valid !== 1'b1 || w_q.size() != 1) begin
            fails++; $display("FAIL stall_output got v%b %0d accepted exp v1 1 accepted", valid, w_q.size());
        end
        tests++;
        if (rd_addr_q.size() != 96 || snap != 96) begin
            fails++; $display("FAIL stall_reads got %0d (mid %0d) exp 96 (mid 96)", rd_addr_q.size(), snap);
        end
        step();
        ready = 1'b1;
        for (int i = 0; i < 600 && w_q.size() < 8; i++) sample();
        errs = 0;
        for (int k = 0; k < 8; k++) if (w_q[k] !== {k == 7, pat(7, k)}) errs++;
        tests++;
        if (w_q.size() != 8 || errs != 0) begin
            fails++; $display("FAIL stall_words got %0d words %0d bad exp 8 words 0 bad", w_q.size(), errs);
        end
        errs = 0;
        for (int i = 0; i < 256; i++) if (rd_addr_q[i] !== 11'(7 * 256 + i)) errs++;
        tests++;
        if (rd_addr_q.size() != 256 || errs != 0) begin
            fails++; $display("FAIL stall_addr_seq got %0d reads %0d bad exp 256 reads 0 bad", rd_addr_q.size(), errs);
        end
    endtask

    task automatic test_back_to_back();
        int errs;
        step();
        clear_logs();
        idx = 3'd0;
        repeat (3) step();
        idx = 3'd1;
        sample();
        tests++;
        if (busy !== 1'b1) begin fails++; $display("FAIL b2b_busy got %b exp 1", busy); end
        for (int i = 0; i < 1200 && w_q.size() < 16; i++) sample();
        errs = 0;
        for (int i = 0; i < 512; i++) if (rd_addr_q[i] !== 11'(i)) errs++;
        tests++;
        if (rd_addr_q.size() != 512 || errs != 0) begin
            fails++; $display("FAIL b2b_addr_seq got %0d reads %0d bad exp 512 reads 0 bad", rd_addr_q.size(), errs);
        end
        errs = 0;
        for (int k = 0; k < 16; k++) if (w_q[k] !== {k % 8 == 7, pat(k / 8, k % 8)}) errs++;
        tests++;
        if (w_q.size() != 16 || errs != 0) begin
            fails++; $display("FAIL b2b_words got %0d words %0d bad exp 16 words 0 bad", w_q.size(), errs);
        end
        tests++;
        if (rd_cyc_q[256] - rd_cyc_q[255] != 4) begin
            fails++; $display("FAIL b2b_gap got %0d exp 4", rd_cyc_q[256] - rd_cyc_q[255]);
        end
        repeat (5) sample();
        tests++;
        if (busy !== 1'b0) begin fails++; $display("FAIL b2b_done_busy got %b exp 0", busy); end
    endtask

    task automatic test_overrun();
        step();
        clear_logs();
        ready = 1'b0;
        for (int e = 0; e < 7; e++) begin
            idx = idx + 3'd1;
            step();
        end
        sample();
        tests++;
        if (ovr !== 1'b0) begin fails++; $display("FAIL ovr_seven got %b exp 0", ovr); end
        step();
        idx = idx + 3'd1;
        step();
        sample();
        tests++;
        if (ovr !== 1'b1) begin fails++; $display("FAIL ovr_eighth got %b exp 1", ovr); end
`ifdef I2S_FRAME_SCHED_RESYNC_EN
        rd_addr_q.delete();
        repeat (5) sample();
        tests++;
        if (rd_addr_q.size() == 0 || rd_addr_q[0] !== {idx, 8'd0}) begin
            fails++; $display("FAIL ovr_resync_addr got %h exp %h", rd_addr_q[0], {idx, 8'd0});
        end
`endif
        step();
        clr = 1'b1;
        step();
        clr = 1'b0;
        sample();
        tests++;
        if (ovr !== 1'b0) begin fails++; $display("FAIL ovr_clear got %b exp 0", ovr); end
`ifndef I2S_FRAME_SCHED_RESYNC_EN
        step();
        idx = idx + 3'd1;
        clr = 1'b1;
        step();
        clr = 1'b0;
        sample();
        tests++;
        if (ovr !== 1'b1) begin fails++; $display("FAIL ovr_set_wins got %b exp 1", ovr); end
`endif
    endtask

    task automatic test_enable();
        int errs;
        step();
        rst = 1'b1; idx = 3'd1; enable = 1'b0; ready = 1'b1; clr = 1'b0;
        step();
        step();
        rst = 1'b0;
        clear_logs();
        errs = 0;
        for (int e = 2; e <= 4; e++) begin
            idx = 3'(e);
            for (int i = 0; i < 5; i++) begin
                step();
                if (busy !== 1'b0) errs++;
            end
        end
        tests++;
        if (errs != 0 || rd_addr_q.size() != 0) begin
            fails++; $display("FAIL en_off got %0d busy cycles %0d reads exp 0 0", errs, rd_addr_q.size());
        end
        enable = 1'b1;
        repeat (20) step();
        tests++;
        if (rd_addr_q.size() != 0) begin fails++; $display("FAIL en_no_stale got %0d reads exp 0", rd_addr_q.size()); end
        idx = 3'd5;
        for (int i = 0; i < 600 && w_q.size() < 8; i++) sample();
        errs = 0;
        for (int i = 0; i < 256; i++) if (rd_addr_q[i] !== 11'(5 * 256 + i)) errs++;
        tests++;
        if (rd_addr_q.size() != 256 || errs != 0) begin
            fails++; $display("FAIL en_addr_seq got %0d reads %0d bad exp 256 reads 0 bad", rd_addr_q.size(), errs);
        end
        errs = 0;
        for (int k = 0; k < 8; k++) if (w_q[k] !== {k == 7, pat(5, k)}) errs++;
        tests++;
        if (w_q.size() != 8 || errs != 0) begin
            fails++; $display("FAIL en_words got %0d words %0d bad exp 8 words 0 bad", w_q.size(), errs);
        end
    endtask

    initial begin
        logic [31:0] w;
        rst = 1'b1; enable = 1'b0; ready = 1'b0; clr = 1'b0; idx = 3'd5;
        for (int f = 0; f < 8; f++)
            for (int k = 0; k < 8; k++) begin
                w = pat(f, k);
                for (int j = 0; j < 32; j++) mem[f * 256 + k * 32 + j] = w[31 - j];
            end
        test_reset();
        test_single_frame();
        test_stall();
        test_back_to_back();
        test_overrun();
        test_enable();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "timeout");
    end
endmodule

// File: doc/i2s_rx_frame_scheduler.md
# i2s_rx_frame_scheduler

Drains completed frames from the I2S receive circular buffer and delivers them as a 32-bit valid/ready word stream toward the USB packetizer. It owns the RAM read port, tracks the receiver's last-good-frame index, and keeps a read frame pointer behind the writer. It detects writer overrun and flags it. It sits between the I2S MSB receiver/RAM and the USB audio IN path.

## Interface
- CIRC_BUF_BITS, 3, log2 of frame slots in the circular buffer; each frame is 256 one-bit entries
- clk_i  in  1  system clock; same clock as the receiver's write side
- rst_i  in  1  synchronous, active-high reset
- enable_i  in  1  allow new frames to start draining
- last_good_frame_idx_i  in  CIRC_BUF_BITS  receiver's most recent completed frame
- ram_read_addr_o  out  CIRC_BUF_BITS+8  {frame, bit}; upper bits are the frame, [7:0] is the bit
- ram_read_en_o  out  1  read strobe; data returns one cycle later
- ram_read_data_i  in  1  RAM read data
- m_data_o  out  32  output word
- m_valid_o  out  1  word valid
- m_ready_i  in  1  sink accepts word
- m_last_o  out  1  word is the 8th (final) word of a frame
- overrun_o  out  1  sticky overrun flag
- overrun_clr_i  in  1  clears overrun_o; set wins if both occur in the same cycle
- busy_o  out  1  frame in progress or pending count nonzero

## Operation
- Completion event: `last_good_frame_idx_i` differs from its registered copy. The receiver advances it by exactly 1 per event.
- Reset behaviour:
  - Copies `last_good_frame_idx_i` into the registered copy.
  - Sets rd_frame to idx+1 and pending to 0.
  - Drives all outputs to 0.
- pending is CIRC_BUF_BITS+1 bits wide:
  - +1 on each completion event.
  - −1 when the `m_last_o` word is accepted.
  - Simultaneous +1 and −1 leaves it unchanged.
- States:
  - IDLE: if pending>0 and enable_i=1, go to READ with bit=0.
  - READ: issue reads at {rd_frame, bit}, bit 0..255, one per cycle.
    - Returned bits shift into a 32-bit assembler, MSB first: RAM bit 32k+j lands in word k, bit 31−j.
    - A full assembler transfers to the output register when that register is empty or being accepted in the same cycle.
    - Otherwise reads stall: ram_read_en_o=0 and the address is held.
    - After bit 255 is issued, go to DRAIN.
  - DRAIN: wait for the final word to transfer. Then rd_frame+1 (mod 2^CIRC_BUF_BITS) and go to IDLE.
- While enable_i=0 in IDLE: pending is forced to 0 and rd_frame follows last_good+1.
- Deasserting enable_i mid-frame does not abort the frame.
- Overrun: a completion event arrives while pending == 2^CIRC_BUF_BITS−1, meaning the writer has entered rd_frame. overrun_o is set; the response is selected by the configuration macro.
- m_valid_o/m_data_o/m_last_o hold stable until accepted. Valid is never withdrawn without a handshake.

## Timing
- RAM read latency is 1 cycle: the bit read in cycle t is captured at the end of cycle t+1.
- Frame start to first word, unstalled: READ entered at t, first read at t, m_valid_o high at t+33.
- With m_ready_i=1 continuously, one word is produced every 32 cycles, so a frame takes 256 read cycles. This matches the receiver write rate.
- IDLE→READ costs 1 cycle per frame. DRAIN lasts 2 cycles when unstalled.
- busy_o is registered and updates one cycle after the causing event.

## Configuration
- I2S_FRAME_SCHED_RESYNC_EN defined, on overrun:
  - Abort the current frame and discard the assembler contents.
  - A word already in the output register still completes, with its m_last_o value unchanged.
  - Set rd_frame to the new last_good index and pending to 1; FSM goes to IDLE.
- Undefined, on overrun:
  - Set overrun_o only. pending saturates at 2^CIRC_BUF_BITS−1.
  - Reading continues in place; torn data is accepted.

## Test plan
- Reset with idx=5, then advance idx to 6 with enable_i=1 and m_ready_i=1 → reads addr {6,0}..{6,255}. 8 words out, m_last_o on the 8th. First m_valid_o 33 cycles after the first read.
- RAM frame 6 holds bit pattern 0xA5A5A5A5 at word 0 and 0x00000001 at word 7 → m_data_o equals exactly those values.
- Hold m_ready_i=0 for 100 cycles mid-frame → ram_read_en_o stops after the assembler fills. m_data_o is stable throughout, and no bits are lost after release.
- Two completion events while busy → pending=2. Frames are delivered back-to-back, and rd_frame wraps 7→0.
- m_ready_i=0 for 8 frame periods with CIRC_BUF_BITS=3 → overrun_o=1. With the RESYNC macro, the next frame read is the newest idx. overrun_clr_i clears the flag.
- enable_i=0 while idx advances 3 times → no reads occur and busy_o=0. After re-enable, only frames completed after that point are read.
